hd44780_ctrl: RTL

Parametrised HD44780-compatible character LCD controller for the PMOD LCD port, successor to the fixed 8-bit LCD driver. It runs the power-on initialisation itself, accepts command/data bytes over a valid/ready write port, and generates the LCD bus in 8-bit or 4-bit mode with cycle-counted enable pulses and execution waits. It tracks the cursor across a ROWS×COLS display and inserts the set-DDRAM command for automatic line wrap. It sits between the system logic and the PMOD pins; its `debug` output drives the PMOD debug LEDs.

---
 rtl/hd44780_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hd44780_ctrl.sv
// HD44780-compatible character LCD controller.
// Runs the power-on init sequence, then accepts command/data bytes over a
// valid/ready port and drives the LCD bus in 8- or 4-bit mode with
// cycle-counted enable pulses and execution waits. Tracks the cursor and
// inserts a set-DDRAM command when a data write runs off the end of a row.
module hd44780_ctrl #(
  parameter int BUS_WIDTH   = 8,
  parameter int ROWS        = 2,
  parameter int COLS        = 16,
  parameter int POWERUP_CYC = 1_500_000,
  parameter int RESET1_CYC  = 410_000,
  parameter int RESET2_CYC  = 10_000,
  parameter int EN_CYC      = 50,
  parameter int CMD_CYC     = 4_000,
  parameter int CLEAR_CYC   = 164_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 wr_rs,
  input  logic [7:0]           wr_data,
  output logic                 init_done,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_en,
  output logic [BUS_WIDTH-1:0] lcd_data,
  output logic [3:0]           debug
);

  localparam bit         FOUR  = (BUS_WIDTH == 4);
  localparam int         LAST  = FOUR ? 7 : 6;
  localparam int         CW    = $clog2(COLS + 1);
  localparam logic [7:0] FBASE = FOUR ? 8'h20 : 8'h30;
  localparam logic [7:0] FSET  = FBASE | ((ROWS > 1) ? 8'h08 : 8'h00);

  typedef enum logic [3:0] {
    S_POWERUP = 4'd0,
    S_INIT    = 4'd1,
    S_IDLE    = 4'd2,
    S_SETUP   = 4'd3,
    S_PULSE   = 4'd4,
    S_HOLD    = 4'd5,
    S_GAP     = 4'd6,
    S_WAIT    = 4'd7,
    S_WRAP    = 4'd8
  } state_t;

  state_t        state, state_n;
  logic [31:0]   cnt;
  logic [31:0]   wait_len;
  logic [2:0]    step;
  logic [7:0]    cur_byte, byte_n;
  logic          cur_rs, rs_n;
  logic          hi, hi_n;          // next pulse carries the high nibble
  logic          single, single_n;  // 4-bit init nibble: one pulse only
  logic [7:0]    word_n;
  logic [1:0]    row, row_nx, drow;
  logic [CW-1:0] col;
  logic [6:0]    addr, off;
  logic          en_n, ready_n, done_n;

  // Init write for each step; 4-bit mode starts with four lone nibbles
  function automatic logic [7:0] init_byte(input logic [2:0] s);
    logic [7:0] b;
    if (FOUR) begin
      case (s)
        3'd0, 3'd1, 3'd2: b = 8'h30;
        3'd3:             b = 8'h20;
        3'd4:             b = FSET;
        3'd5:             b = 8'h0C;
        3'd6:             b = 8'h01;
        default:          b = 8'h06;
      endcase
    end else begin
      case (s)
        3'd0, 3'd1, 3'd2: b = 8'h30;
        3'd3:             b = FSET;
        3'd4:             b = 8'h0C;
        3'd5:             b = 8'h01;
        default:          b = 8'h06;
      endcase
    end
    return b;
  endfunction

  // DDRAM base address of each display row
  function automatic logic [6:0] row_base(input logic [1:0] r);
    logic [6:0] a;
    case (r)
      2'd0:    a = 7'h00;
      2'd1:    a = 7'h40;
      2'd2:    a = 7'h14;
      default: a = 7'h54;
    endcase
    return a;
  endfunction

  assign lcd_rw = 1'b0;
  assign debug  = state;
  assign row_nx = (row == 2'(ROWS - 1)) ? 2'd0 : row + 2'd1;

  // Execution wait: the first two init writes have their own long waits
  always_comb begin
    if (!init_done && step == 3'd0)
      wait_len = 32'(RESET1_CYC);
    else if (!init_done && step == 3'd1)
      wait_len = 32'(RESET2_CYC);
    else if (!cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02))
      wait_len = 32'(CLEAR_CYC);
    else
      wait_len = 32'(CMD_CYC);
  end

  // Decode the row/column addressed by an incoming set-DDRAM command
  always_comb begin
    addr = wr_data[6:0];
    drow = 2'd0;
    if (ROWS == 4 && addr >= 7'h54)      drow = 2'd3;
    else if (ROWS >= 2 && addr >= 7'h40) drow = 2'd1;
    else if (ROWS == 4 && addr >= 7'h14) drow = 2'd2;
    off = addr - row_base(drow);
  end

  // State register and per-state cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_POWERUP;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + 32'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_POWERUP: if (cnt == 32'(POWERUP_CYC - 1)) state_n = S_SETUP;
      S_INIT:    state_n = S_SETUP;
      S_IDLE:    if (wr_valid) state_n = S_SETUP;
      S_SETUP:   state_n = S_PULSE;
      S_PULSE:   if (cnt == 32'(EN_CYC - 1)) state_n = S_HOLD;
      S_HOLD:    state_n = (FOUR && hi && !single) ? S_GAP : S_WAIT;
      S_GAP:     if (cnt == 32'(EN_CYC - 1)) state_n = S_SETUP;
      S_WAIT: begin
        if (cnt == wait_len - 32'd1) begin
          if (!init_done)             state_n = (step == 3'(LAST)) ? S_IDLE : S_INIT;
          else if (col == CW'(COLS))  state_n = S_WRAP;
          else                        state_n = S_IDLE;
        end
      end
      S_WRAP:    state_n = S_SETUP;
      default:   state_n = S_POWERUP;
    endcase
  end

  // Transfer contents loaded on entry to SETUP, by source
  always_comb begin
    byte_n   = cur_byte;
    rs_n     = cur_rs;
    hi_n     = hi;
    single_n = single;
    if (state_n == S_SETUP) begin
      case (state)
        S_POWERUP, S_INIT: begin
          byte_n   = init_byte(step);
          rs_n     = 1'b0;
          hi_n     = 1'b1;
          single_n = FOUR && (step <= 3'd3);
        end
        S_IDLE: begin
          byte_n   = wr_data;
          rs_n     = wr_rs;
          hi_n     = 1'b1;
          single_n = 1'b0;
        end
        S_GAP:   hi_n = 1'b0;
        S_WRAP: begin
          byte_n   = {1'b1, row_base(row_nx)};
          rs_n     = 1'b0;
          hi_n     = 1'b1;
          single_n = 1'b0;
        end
        default: ;
      endcase
    end
    word_n = FOUR ? {4'h0, (hi_n ? byte_n[7:4] : byte_n[3:0])} : byte_n;
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    en_n    = (state_n == S_PULSE);
    ready_n = (state_n == S_IDLE);
    done_n  = init_done || (state == S_WAIT && state_n == S_IDLE);
  end

  // Transfer datapath registers and init step pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_byte <= '0;
      cur_rs   <= 1'b0;
      hi       <= 1'b0;
      single   <= 1'b0;
      step     <= '0;
    end else begin
      cur_byte <= byte_n;
      cur_rs   <= rs_n;
      hi       <= hi_n;
      single   <= single_n;
      if (state == S_WAIT && state_n == S_INIT) step <= step + 3'd1;
    end
  end

  // Registered LCD pins and handshake; bus only changes entering SETUP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_en    <= 1'b0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
    end else begin
      lcd_en    <= en_n;
      wr_ready  <= ready_n;
      init_done <= done_n;
      if (state_n == S_SETUP) begin
        lcd_rs   <= rs_n;
        lcd_data <= word_n[BUS_WIDTH-1:0];
      end
    end
  end

  // Cursor tracking: updated on accept, zeroed after init, advanced on wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (state == S_WAIT && state_n == S_IDLE && !init_done) begin
      row <= '0;
      col <= '0;
    end else if (state == S_IDLE && wr_valid) begin
      if (wr_rs) begin
        col <= col + CW'(1);
      end else if (wr_data == 8'h01 || wr_data == 8'h02) begin
        row <= '0;
        col <= '0;
      end else if (wr_data[7]) begin
        row <= drow;
        col <= (off >= 7'(COLS)) ? CW'(COLS - 1) : CW'(off);
      end
    end else if (state == S_WRAP) begin
      row <= row_nx;
      col <= '0;
    end
  end

endmodule
